priority_code_decoder: RTL

//   Receive end of the 4-line priority-encoder interface. Takes the encoded
//   {X,Y} code plus its valid flag V, and produces a registered one-hot line.

---
 rtl/priority_code_decoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/priority_code_decoder.sv
// priority_code_decoder: registered one-hot decode of a 4-line priority-encoder
// code, with sticky pending/overflow tracking and a valid/ready service port
// that offers the highest-index pending line first.
module priority_code_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_v,
    input  logic [1:0]       in_code,
    output logic [3:0]       dec_onehot,
    output logic [3:0]       pend,
    output logic [3:0]       ovf,
    input  logic [3:0]       ovf_clr,
    output logic             svc_valid,
    output logic [1:0]       svc_idx,
    input  logic             svc_ready,
    output logic [CNT_W-1:0] evt_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       dec_q, dec_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       set_vec;
    logic [3:0]       clr_vec;
    logic             hs;

    // Event/clear vectors and next values of decode, pending, overflow and counter
    always_comb begin
        set_vec = '0;
        if (in_v) begin
            set_vec[in_code] = 1'b1;
        end
        hs      = (state_q == OFFER) && svc_ready;
        clr_vec = '0;
        if (hs) begin
            clr_vec[idx_q] = 1'b1;
        end
        dec_d  = set_vec;
        // A new event on a line being cleared re-arms it; set wins over clear.
        pend_d = (pend_q & ~clr_vec) | set_vec;
        // Overflow only when the line is still pending after this cycle's clear.
        ovf_d  = (ovf_q & ~ovf_clr) | (set_vec & pend_q & ~clr_vec);
        cnt_d  = cnt_q;
        if (in_v && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q  <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            dec_q  <= dec_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    // Service FSM state register and latched index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Service FSM next state: latch highest pending line in IDLE, hold until ready
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d = OFFER;
                    if (pend_q[3])      idx_d = 2'd3;
                    else if (pend_q[2]) idx_d = 2'd2;
                    else if (pend_q[1]) idx_d = 2'd1;
                    else                idx_d = 2'd0;
                end
            end
            OFFER: begin
                if (svc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        svc_valid  = (state_q == OFFER);
        svc_idx    = idx_q;
        dec_onehot = dec_q;
        pend       = pend_q;
        ovf        = ovf_q;
        evt_cnt    = cnt_q;
    end

endmodule
